usb_frame_streamer: RTL and testbench
=====================================

// Module: usb_frame_streamer
// PURPOSE
//  Parametrised successor of the FT600 USB bridge, in one clock domain (the FT600 CLK).
//  Captures one frame of NUM_CH x DEPTH samples on a start_sending rising edge.
//  Streams the frame to the host over the 245-sync FIFO bus: header, frame count, then samples.
//  Honours TXE_N backpressure and receives host command words between frames.
// PARAMETERS
//  DATA_W   16       sample/bus word width (FT600 = 16)
//  NUM_CH   2        channels captured per frame (1..8)
//  DEPTH    128      samples per channel per frame (power of 2, >=2)
//  HEADER   16'hA55A first word of every frame
// PORTS
//  clk            in   1              FT600 CLK; the only clock
//  reset          in   1              synchronous, active-low
//  start_sending  in   1              rising edge requests a capture+send
//  data_in        in   NUM_CH*DATA_W  channel c at [c*DATA_W +: DATA_W]; valid same cycle as read_index
//  read_index     out  $clog2(DEPTH)  sample address presented to upstream sample memories
//  busy           out  1              high from capture start until last word accepted
//  command        out  DATA_W         last host command word (reset 0 = NOOP)
//  command_valid  out  1              1-cycle pulse when command updates
//  TXE_N, RXF_N   in   1              FT600 tx-space / rx-data flags, active-low
//  OE_N, RD_N, WR_N out 1             FT600 strobes, active-low
//  DATA           inout DATA_W        FT600 data bus
//  BE             inout 2             byte enables; 2'b11 when driven
// BEHAVIOUR
//  Reset (reset==0 at posedge)
//   - OE_N=RD_N=WR_N=1, busy=0, command=0, command_valid=0, read_index=0; bus released.
//   - Frame counter cleared. Mid-operation reset aborts any frame or read; nothing is resumed.
//  Bus drive
//   - DATA/BE driven only while OE_N==1 and in SEND; Z otherwise.
//   - Never driven in the same cycle as OE_N==0.
//  FSM states and transitions
//   - IDLE: RXF_N==0 has priority -> RD_OE. Else start_sending rising edge (registered prev) -> CAPTURE, busy=1.
//   - RD_OE: OE_N<=0 (turnaround cycle) -> RD.
//   - RD: RD_N<=0; on each posedge with RD_N==0 and RXF_N==0, a word is taken.
//     - The first word of the burst goes to command with a command_valid pulse; extra words are discarded.
//     - When RXF_N==1: OE_N=RD_N=1 -> IDLE.
//   - CAPTURE: read_index counts 0..DEPTH-1, one per cycle.
//     - Each cycle all channels are written to buffer[c][read_index].
//     - After DEPTH-1 -> SEND. Capture latency is exactly DEPTH cycles.
//   - SEND: word sequence is HEADER, frame_cnt, ch0[0..DEPTH-1], ..., ch(NUM_CH-1)[..].
//     - Total is 2+NUM_CH*DEPTH words.
//     - WR_N=0 throughout. A word is transferred on a posedge where WR_N==0 and TXE_N==0; only then does the word pointer advance.
//     - TXE_N==1 holds the current word (stall of any length, no loss or duplicate).
//     - After the last transfer: WR_N=1, frame_cnt+=1 (wraps at 2^DATA_W) -> WAIT_LOW.
//   - WAIT_LOW: busy=0; -> IDLE when start_sending==0.
//  Boundary conditions
//   - start_sending edges during CAPTURE, SEND or RD are ignored, not queued.
//   - RXF_N falling during CAPTURE or SEND is serviced only after the frame ends.
//   - An RXF_N burst of exactly 1 word must still latch command.
// STRUCTURE
//  Shared package usb_pkg:
//   - FSM state encoding.
//   - COMMAND_NOOP=0 and the command codes.
//   - FT600 BE constant.
//  One sub-module, usb_frame_buffer:
//   - NUM_CH x DEPTH x DATA_W RAM.
//   - Write port is all channels at one address.
//   - Read port is {ch,idx} with 1-cycle registered read; SEND prefetches to hide it.
//  Top level holds the FSM, word pointer, frame counter and tri-state drivers.
// TESTING
//  1. Reset low 3 cycles mid-SEND -> strobes=1, DATA=Z, busy=0; next start gives frame_cnt=0.
//  2. NUM_CH=2, DEPTH=4, data ch0=idx+1, ch1=idx+16'h10, TXE_N=0 ->
//     host sees A55A,0000,1,2,3,4,10,11,12,13 in 10 consecutive cycles.
//  3. Same frame, TXE_N=1 for 3 cycles at word 5 -> identical 10-word sequence, no duplicates.
//  4. RXF_N low 1 word, DATA=16'h0003 -> OE_N falls, RD_N falls next cycle, command=3, one command_valid pulse.
//  5. RXF_N low during CAPTURE -> frame completes first, then command read.
//     Second start_sending held high -> no second frame until it drops and rises again.
//  6. Send 2 frames -> frame_cnt words 0 then 1; start_sending pulse during SEND is ignored.

Source files
------------

// File: rtl/usb_pkg.sv
// Shared types and constants for the FT600 frame streamer.
package usb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_OE,
    S_RD,
    S_CAPTURE,
    S_SEND,
    S_WAIT_LOW
  } state_t;

  typedef enum logic [15:0] {
    CMD_NOOP    = 16'h0000,
    CMD_START   = 16'h0001,
    CMD_STOP    = 16'h0002,
    CMD_CLR_CNT = 16'h0003
  } cmd_t;

  localparam logic [15:0] COMMAND_NOOP = 16'(CMD_NOOP);
  localparam logic [1:0]  FT600_BE     = 2'b11;

endpackage

// File: rtl/usb_frame_buffer.sv
// Frame RAM: all channels written at one sample index, one word read per cycle
// with a registered output.
module usb_frame_buffer
  import usb_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 128,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [IDX_W-1:0]         wr_idx,
  input  logic [NUM_CH*DATA_W-1:0] wr_data,
  input  logic [CH_W-1:0]          rd_ch,
  input  logic [IDX_W-1:0]         rd_idx,
  output logic [DATA_W-1:0]        rd_data
);

  logic [DATA_W-1:0] mem [NUM_CH][DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int c = 0; c < NUM_CH; c++) begin
        mem[c][wr_idx] <= wr_data[c*DATA_W +: DATA_W];
      end
    end
    rd_data_q <= mem[rd_ch][rd_idx];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/usb_frame_streamer.sv
// Captures one NUM_CH x DEPTH frame and streams it over the FT600 245-sync FIFO
// bus; reads host command words between frames.
//   state      | meaning
//   S_IDLE     | waiting for host data (priority) or a start edge
//   S_RD_OE    | OE_N low, bus turnaround before RD_N
//   S_RD       | RD_N low, first word of the burst becomes the command
//   S_CAPTURE  | one sample index per cycle written into the buffer
//   S_SEND     | header, frame count, samples; advances only when TXE_N low
//   S_WAIT_LOW | frame done, waiting for start_sending to drop
module usb_frame_streamer
  import usb_pkg::*;
#(
  parameter int                DATA_W = 16,
  parameter int                NUM_CH = 2,
  parameter int                DEPTH  = 128,
  parameter logic [DATA_W-1:0] HEADER = 16'hA55A
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start_sending,
  input  logic [NUM_CH*DATA_W-1:0]   data_in,
  output logic [$clog2(DEPTH)-1:0]   read_index,
  output logic                       busy,
  output logic [DATA_W-1:0]          command,
  output logic                       command_valid,
  input  logic                       TXE_N,
  input  logic                       RXF_N,
  output logic                       OE_N,
  output logic                       RD_N,
  output logic                       WR_N,
  inout  wire  [DATA_W-1:0]          DATA,
  inout  wire  [1:0]                 BE
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SAMP_W = IDX_W + CH_W;
  localparam int TOTAL  = 2 + NUM_CH * DEPTH;
  localparam int PTR_W  = $clog2(TOTAL);

  state_t            state_q, state_d;
  logic              oe_n_q, oe_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
  logic              busy_q, busy_d, first_q, first_d;
  logic              start_prev_q, start_prev_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [DATA_W-1:0] cmd_q, cmd_d, frame_cnt_q, frame_cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [SAMP_W-1:0] rd_addr;
  logic [DATA_W-1:0] buf_rd_data, send_word;
  logic              drive;

  always_comb begin
    state_d      = state_q;
    oe_n_d       = oe_n_q;
    rd_n_d       = rd_n_q;
    wr_n_d       = wr_n_q;
    busy_d       = busy_q;
    first_d      = first_q;
    start_prev_d = start_sending;
    cmd_valid_d  = 1'b0;
    cmd_d        = cmd_q;
    frame_cnt_d  = frame_cnt_q;
    idx_d        = idx_q;
    wptr_d       = wptr_q;
    case (state_q)
      S_IDLE: begin
        if (!RXF_N) begin
          state_d = S_RD_OE;
          oe_n_d  = 1'b0;
        end else if (start_sending && !start_prev_q) begin
          state_d = S_CAPTURE;
          busy_d  = 1'b1;
          idx_d   = '0;
        end
      end
      S_RD_OE: begin
        state_d = S_RD;
        rd_n_d  = 1'b0;
        first_d = 1'b1;
      end
      S_RD: begin
        if (RXF_N) begin
          state_d = S_IDLE;
          oe_n_d  = 1'b1;
          rd_n_d  = 1'b1;
        end else if (first_q) begin
          cmd_d       = DATA;
          cmd_valid_d = 1'b1;
          first_d     = 1'b0;
        end
      end
      S_CAPTURE: begin
        if (idx_q == IDX_W'(DEPTH - 1)) begin
          state_d = S_SEND;
          wr_n_d  = 1'b0;
          wptr_d  = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_SEND: begin
        if (!TXE_N) begin
          if (wptr_q == PTR_W'(TOTAL - 1)) begin
            state_d     = S_WAIT_LOW;
            wr_n_d      = 1'b1;
            busy_d      = 1'b0;
            frame_cnt_d = frame_cnt_q + DATA_W'(1);
          end else begin
            wptr_d = wptr_q + PTR_W'(1);
          end
        end
      end
      S_WAIT_LOW: begin
        if (!start_sending) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      oe_n_q       <= 1'b1;
      rd_n_q       <= 1'b1;
      wr_n_q       <= 1'b1;
      busy_q       <= 1'b0;
      first_q      <= 1'b0;
      start_prev_q <= 1'b0;
      cmd_valid_q  <= 1'b0;
      cmd_q        <= DATA_W'(COMMAND_NOOP);
      frame_cnt_q  <= '0;
      idx_q        <= '0;
      wptr_q       <= '0;
    end else begin
      state_q      <= state_d;
      oe_n_q       <= oe_n_d;
      rd_n_q       <= rd_n_d;
      wr_n_q       <= wr_n_d;
      busy_q       <= busy_d;
      first_q      <= first_d;
      start_prev_q <= start_prev_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_q        <= cmd_d;
      frame_cnt_q  <= frame_cnt_d;
      idx_q        <= idx_d;
      wptr_q       <= wptr_d;
    end
  end

  // Read address follows the next pointer so the registered RAM output lines
  // up with wptr_q, hiding the read latency even across stalls.
  assign rd_addr = SAMP_W'(wptr_d - PTR_W'(2));

  usb_frame_buffer #(
    .DATA_W (DATA_W),
    .NUM_CH (NUM_CH),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W),
    .CH_W   (CH_W)
  ) u_buf (
    .clk     (clk),
    .we      (state_q == S_CAPTURE),
    .wr_idx  (idx_q),
    .wr_data (data_in),
    .rd_ch   (rd_addr[SAMP_W-1 -: CH_W]),
    .rd_idx  (rd_addr[IDX_W-1:0]),
    .rd_data (buf_rd_data)
  );

  always_comb begin
    send_word = buf_rd_data;
    if (wptr_q == PTR_W'(0))      send_word = HEADER;
    else if (wptr_q == PTR_W'(1)) send_word = frame_cnt_q;
  end

  assign drive = (state_q == S_SEND) && oe_n_q;
  assign DATA  = drive ? send_word : {DATA_W{1'bz}};
  assign BE    = drive ? FT600_BE : 2'bzz;

  assign read_index    = idx_q;
  assign busy          = busy_q;
  assign command       = cmd_q;
  assign command_valid = cmd_valid_q;
  assign OE_N          = oe_n_q;
  assign RD_N          = rd_n_q;
  assign WR_N          = wr_n_q;

endmodule

// File: tb/tb_usb_frame_streamer.sv
// Scoreboard bench for usb_frame_streamer with NUM_CH=2, DEPTH=4.
module tb_usb_frame_streamer;
  localparam int DATA_W = 16;
  localparam int NUM_CH = 2;
  localparam int DEPTH  = 4;
  localparam int TOTAL  = 2 + NUM_CH * DEPTH;

  logic clk = 1'b0, reset = 1'b0, start_sending = 1'b0;
  logic TXE_N = 1'b0, RXF_N = 1'b1;
  logic [NUM_CH*DATA_W-1:0] data_in;
  logic [1:0]  read_index;
  logic        busy, command_valid, OE_N, RD_N, WR_N;
  logic [15:0] command;
  wire  [15:0] DATA;
  wire  [1:0]  BE;
  logic [15:0] host_data = 16'h0, pat_off = 16'h0, ri;
  logic        force_bus = 1'b0;

  int n_chk = 0, n_fail = 0;
  int xfer_cnt = 0, cv_cnt = 0, cyc = 0, first_cyc = 0, last_cyc = 0, frame_base = 0;
  int cv0;
  logic [15:0] exp_q[$];
  logic [15:0] cmd_q[$];

  assign ri      = {14'd0, read_index};
  assign data_in = {ri + 16'h10 + pat_off, ri + 16'h1 + pat_off};
  assign DATA    = (!OE_N || force_bus) ? host_data : 16'hzzzz;

  usb_frame_streamer #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .HEADER(16'hA55A)) dut (
    .clk(clk), .reset(reset), .start_sending(start_sending), .data_in(data_in),
    .read_index(read_index), .busy(busy), .command(command), .command_valid(command_valid),
    .TXE_N(TXE_N), .RXF_N(RXF_N), .OE_N(OE_N), .RD_N(RD_N), .WR_N(WR_N),
    .DATA(DATA), .BE(BE)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: bus transfers and command updates, compared against the queues.
  initial forever begin
    @(negedge clk);
    if (reset && !WR_N && !TXE_N) begin
      if (xfer_cnt == frame_base) first_cyc = cyc;
      last_cyc = cyc;
      xfer_cnt++;
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL word_unexpected: got %0h expected none", DATA);
      end else check("frame_word", DATA, exp_q.pop_front());
      check("be_driven", BE, 2'b11);
    end
    if (reset && command_valid) begin
      cv_cnt++;
      check("cmd_while_busy", busy, 0);
      if (cmd_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL cmd_unexpected: got %0h expected none", command);
      end else check("command", command, cmd_q.pop_front());
    end
  end

  task automatic send_frame(input logic [15:0] cnt, input logic [15:0] off,
                            input int stall_at, input bit pulse_mid, input bit hold);
    int c1;
    bit done = 0, stalled = 0, pulsed = 0;
    pat_off = off;
    exp_q.push_back(16'hA55A);
    exp_q.push_back(cnt);
    for (int c = 0; c < NUM_CH; c++)
      for (int i = 0; i < DEPTH; i++)
        exp_q.push_back(c == 0 ? 16'(i + 1) + off : 16'(i) + 16'h10 + off);
    frame_base = xfer_cnt;
    start_sending = 1'b1;
    @(posedge clk); #1;
    c1 = cyc;
    check("busy_rise", busy, 1);
    if (!hold) start_sending = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(posedge clk); #1;
      if (stall_at >= 0 && !stalled && xfer_cnt == frame_base + stall_at) begin
        TXE_N = 1'b1;
        repeat (3) @(posedge clk);
        #1 TXE_N = 1'b0;
        stalled = 1;
      end
      if (pulse_mid && !pulsed && xfer_cnt == frame_base + 3) begin
        start_sending = 1'b1;
        @(posedge clk);
        #1 start_sending = 1'b0;
        pulsed = 1;
      end
      if (!busy) done = 1;
    end
    check("frame_done", done, 1);
    check("words_left", exp_q.size(), 0);
    check("capture_latency", first_cyc - c1, DEPTH);
    if (stall_at < 0) check("burst_cycles", last_cyc - first_cyc, TOTAL - 1);
    else              check("stall_cycles", last_cyc - first_cyc, TOTAL - 1 + 3);
  endtask

  task automatic host_send(input logic [15:0] w0, input int n);
    int taken = 0;
    cmd_q.push_back(w0);
    host_data = w0;
    RXF_N = 1'b0;
    for (int c = 0; c < 400 && taken < n; c++) begin
      @(negedge clk);
      if (!RD_N && !RXF_N) begin
        taken++;
        @(posedge clk); #1;
        if (taken == n) RXF_N = 1'b1;
        else host_data = w0 + 16'(taken * 16'h100);
      end
    end
    if (taken < n) begin
      n_chk++; n_fail++;
      $display("FAIL host_read_timeout: got %0d words expected %0d", taken, n);
      RXF_N = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_oe_n", OE_N, 1);
    check("rst_rd_n", RD_N, 1);
    check("rst_wr_n", WR_N, 1);
    check("rst_busy", busy, 0);
    check("rst_command", command, 0);
    check("rst_cmd_valid", command_valid, 0);
    check("rst_read_index", read_index, 0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Plain frame, stalled frame, frame with a start pulse mid-SEND
    send_frame(16'd0, 16'h0000, -1, 0, 0);
    repeat (2) @(posedge clk); #1;
    send_frame(16'd1, 16'h0000, 5, 0, 0);
    repeat (2) @(posedge clk); #1;
    send_frame(16'd2, 16'h0100, -1, 1, 0);
    repeat (20) @(posedge clk); #1;
    check("pulse_ignored", busy, 0);
    check("pulse_no_words", xfer_cnt, 3 * TOTAL);

    // Reset mid-SEND while the host is stalling
    TXE_N = 1'b1;
    start_sending = 1'b1;
    @(posedge clk); #1 start_sending = 1'b0;
    repeat (DEPTH + 3) @(posedge clk); #1;
    check("abort_in_send", WR_N, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    force_bus = 1'b1;
    host_data = 16'hC3C3;
    @(negedge clk);
    check("abort_oe_n", OE_N, 1);
    check("abort_rd_n", RD_N, 1);
    check("abort_wr_n", WR_N, 1);
    check("abort_busy", busy, 0);
    check("abort_bus_released", DATA, 16'hC3C3);
    repeat (2) @(posedge clk); #1;
    force_bus = 1'b0;
    reset = 1'b1;
    TXE_N = 1'b0;
    repeat (2) @(posedge clk); #1;
    send_frame(16'd0, 16'h0040, -1, 0, 0);
    repeat (3) @(posedge clk); #1;

    // Single-word host read with strobe timing, then a 3-word burst
    cv0 = cv_cnt;
    fork
      host_send(16'h0003, 1);
      begin
        @(negedge clk); check("rd_oe_n_pre", OE_N, 1);
        @(negedge clk); check("rd_oe_n_fall", OE_N, 0); check("rd_rd_n_wait", RD_N, 1);
        @(negedge clk); check("rd_rd_n_fall", RD_N, 0);
      end
    join
    repeat (3) @(posedge clk); #1;
    check("rd1_pulses", cv_cnt - cv0, 1);
    check("rd1_oe_release", OE_N, 1);
    check("rd1_command", command, 16'h0003);
    cv0 = cv_cnt;
    host_send(16'h0007, 3);
    repeat (3) @(posedge clk); #1;
    check("rd3_pulses", cv_cnt - cv0, 1);
    check("rd3_command", command, 16'h0007);

    // Host data arriving during CAPTURE with start held high
    cv0 = cv_cnt;
    fork
      begin
        send_frame(16'd1, 16'h0200, -1, 0, 1);
        repeat (20) @(posedge clk); #1;
        check("held_no_refire", busy, 0);
        check("held_read_deferred", cv_cnt - cv0, 0);
        check("held_oe_n", OE_N, 1);
        start_sending = 1'b0;
      end
      begin
        repeat (3) @(posedge clk); #1;
        host_send(16'h0005, 1);
      end
    join
    repeat (3) @(posedge clk); #1;
    check("deferred_pulses", cv_cnt - cv0, 1);
    check("deferred_command", command, 16'h0005);
    send_frame(16'd2, 16'h0300, -1, 0, 0);
    repeat (3) @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
